// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the RISC-V I/S/B/J/U field layout of base_instr,
// one registered output beat. Define IMM_ENC_LI_EXPAND_EN to split an oversize `li` into LUI+ADDI.
module imm_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] base_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_err
);

  typedef enum logic {RUN, SECOND} state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] hold, hold_d, instr_d;
  logic [DATA_WIDTH-1:0] enc_instr, first_instr, first_hold;
  logic                  enc_err, first_err, li_hit, valid_d, err_d;
  logic                  i_fit, b_fit, j_fit, u_fit;

  assign i_fit = imm == {{20{imm[11]}}, imm[11:0]};
  assign b_fit = !imm[0] && (imm == {{19{imm[12]}}, imm[12:0]});
  assign j_fit = !imm[0] && (imm == {{11{imm[20]}}, imm[20:0]});
  assign u_fit = imm[11:0] == 12'd0;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    enc_instr = base_instr;
    enc_err   = 1'b0;
    unique case (ImmSrc)
      3'b000: begin
        enc_instr[31:20] = imm[11:0];
        enc_err          = !i_fit;
      end
      3'b001: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        enc_err          = !i_fit;
      end
      3'b010: begin
        enc_instr[31]    = imm[12];
        enc_instr[30:25] = imm[10:5];
        enc_instr[11:8]  = imm[4:1];
        enc_instr[7]     = imm[11];
        enc_err          = !b_fit;
      end
      3'b011: begin
        enc_instr[31]    = imm[20];
        enc_instr[30:21] = imm[10:1];
        enc_instr[20]    = imm[11];
        enc_instr[19:12] = imm[19:12];
        enc_err          = !j_fit;
      end
      3'b100: begin
        enc_instr[31:12] = imm[31:12];
        enc_err          = !u_fit;
      end
      default: enc_err = 1'b1;
    endcase
  end

`ifdef IMM_ENC_LI_EXPAND_EN
  logic [DATA_WIDTH-1:0] li_sum;

  // Rounding by 0x800 lets the sign-extended ADDI low part correct the LUI value.
  assign li_sum      = imm + 32'h0000_0800;
  assign li_hit      = (ImmSrc == 3'b000) && (base_instr[6:0] == 7'b0010011) &&
                       (base_instr[14:12] == 3'b000) && (base_instr[19:15] == 5'd0) && !i_fit;
  assign first_instr = li_hit ? {li_sum[31:12], base_instr[11:7], 7'b0110111} : enc_instr;
  assign first_err   = li_hit ? 1'b0 : enc_err;
  assign first_hold  = {imm[11:0], base_instr[11:7], 3'b000, base_instr[11:7], 7'b0010011};
`else
  assign li_hit      = 1'b0;
  assign first_instr = enc_instr;
  assign first_err   = enc_err;
  assign first_hold  = '0;
`endif

  always_comb begin
    state_d  = state;
    valid_d  = out_valid;
    instr_d  = out_instr;
    err_d    = out_err;
    hold_d   = hold;
    in_ready = 1'b0;
    unique case (state)
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready) begin
          valid_d = 1'b1;
          instr_d = first_instr;
          err_d   = first_err;
          if (li_hit) begin
            hold_d  = first_hold;
            state_d = SECOND;
          end
        end else if (out_ready) begin
          valid_d = 1'b0;
        end
      end
      SECOND: begin
        if (out_ready) begin
          instr_d = hold;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the hold register is reset as well, so a pending second beat is
      // discarded rather than reappearing after reset.
      state     <= RUN;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      hold      <= '0;
    end else begin
      state     <= state_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_err   <= err_d;
      hold      <= hold_d;
    end
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender: packs a 32-bit immediate into the scattered RISC-V immediate field positions of an instruction word, selected by the same 3-bit ImmSrc format code.
- Sits in the test/boot instruction-generation path that produces instruction words for instruction memory.
- Valid/ready stream in, valid/ready stream out, one registered output beat.
- Flags immediates that the chosen format cannot represent. Optionally expands out-of-range `li` (ADDI rd, x0, imm) into a LUI+ADDI pair.

Parameters:
DATA_WIDTH, 32, instruction and immediate width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready at a rising edge
ImmSrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U; 101-111 invalid
imm  input  32  immediate value (byte offset for B/J, full upper value for U)
base_instr  input  32  opcode/rd/rs1/rs2/funct fields; bits in the selected immediate field are ignored
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts beat when out_valid && out_ready
out_instr  output  32  encoded instruction
out_err  output  1  immediate not representable in the selected format (beat still emitted)

Behaviour:
- Reset (async, any state): out_valid=0, out_instr=0, out_err=0, state=RUN, hold register cleared. A pending second beat is discarded.
- Packing: non-immediate bits are taken from base_instr.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
  - Invalid code: out_instr=base_instr, out_err=1.
- Representability: out_err=1 when the check fails. Packed bits are always the truncated values above.
  - I/S: imm equals sign-extension of imm[11:0].
  - B: imm[0]=0 and imm equals sign-extension of imm[12:0].
  - J: imm[0]=0 and imm equals sign-extension of imm[20:0].
  - U: imm[11:0]=0.
- States: RUN, SECOND.
- RUN:
  - in_ready = !out_valid || out_ready.
  - On accept, the output register is loaded at that edge (latency 1 cycle) and out_valid=1.
  - If no accept and out_ready, out_valid falls to 0.
  - Simultaneous output drain and new accept in the same cycle is allowed, giving full throughput.
- SECOND:
  - in_ready=0.
  - When out_ready, load the hold register into the output (out_err=0) and return to RUN.
- Output stability: while out_valid && !out_ready, out_instr and out_err hold constant.

Optional Feature:
- Macro: IMM_ENC_LI_EXPAND_EN.
- With the macro defined:
  - Trigger: request with ImmSrc=000, base_instr[6:0]=0010011, [14:12]=000, [19:15]=0, and imm failing the I-range check.
  - First beat is LUI rd: out_instr = {hi, base_instr[11:7], 0110111}, where hi=(imm+0x800)>>12 (mod 2^20).
  - Hold register = ADDI rd, rd, imm[11:0].
  - FSM goes to SECOND. out_err=0 on both beats.
- Without the macro: no SECOND state is reachable. The same request emits one truncated ADDI with out_err=1.

Test Plan:
- Reset then ImmSrc=000, imm=0xFFFFFFFF, base_instr=0x00000093 -> one cycle later out_valid=1, out_instr=0xFFF00093, out_err=0.
- ImmSrc=010, imm=0xFFFFFFFC, base_instr=0x00000063 -> out_instr=0xFE000EE3, out_err=0. Repeat with imm=0x00000003 -> out_err=1.
- ImmSrc=011, imm=0x00000800, base_instr=0x000000EF -> out_instr=0x001000EF. ImmSrc=100, imm=0x00001234 -> out_err=1, out_instr[31:12]=0x00001.
- Back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0, out_instr stable. Release -> requests emerge in order with no loss or duplication.
- With IMM_ENC_LI_EXPAND_EN: ImmSrc=000, imm=0x12345FFF, base_instr=0x00000293 -> beats 0x123462B7 then 0xFFF28293, in_ready=0 between them. Without the macro -> single beat 0xFFF00293, out_err=1.
- Assert rst while in SECOND -> out_valid=0 immediately, second beat never emitted. After release, in_ready=1 and the next request encodes correctly.
